// File: rtl/iotdf_round_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// iotdf_round_arb: grants one IOTDF core a whole round at a time to one of two
// requesters and serializes 128-bit records into the core byte stream.
// Rev 1.0
// ---------------------------------------------------------------------------
module iotdf_round_arb #(
  parameter int ROUND_LEN = 8,
  parameter int DRAIN_CYC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [127:0] req_data0,
  input  logic [127:0] req_data1,
  input  logic [2:0]   req_fn0,
  input  logic [2:0]   req_fn1,
  output logic         in_en,
  output logic [7:0]   iot_in,
  output logic [2:0]   fn_sel,
  input  logic         busy,
  input  logic         valid,
  input  logic [127:0] iot_out,
  output logic         res_valid,
  output logic [127:0] res_data,
  output logic         res_src
);

  localparam int RC_W = (ROUND_LEN > 1) ? $clog2(ROUND_LEN) : 1;
  localparam int DC_W = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
  localparam logic [RC_W-1:0] REC_LAST   = RC_W'(ROUND_LEN - 1);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_CYC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SEND  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          state;
  logic            cur_src;
  logic            last_src;
  logic [RC_W-1:0] rec_cnt;
  logic [3:0]      byte_cnt;
  logic [DC_W-1:0] drain_cnt;
  logic [127:0]    shreg;

  logic            grant_src;
  logic            owner_valid;

  // On a tie the requester that did not own the previous round wins.
  assign grant_src   = (&req_valid) ? ~last_src : req_valid[1];
  assign owner_valid = cur_src ? req_valid[1] : req_valid[0];

  always_comb begin
    req_ready = 2'b00;
    if (state == S_LOAD) begin
      req_ready = {cur_src & req_valid[1], ~cur_src & req_valid[0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cur_src   <= 1'b0;
      last_src  <= 1'b1;
      fn_sel    <= 3'd0;
      rec_cnt   <= '0;
      byte_cnt  <= 4'd0;
      drain_cnt <= '0;
      shreg     <= 128'd0;
      in_en     <= 1'b0;
      iot_in    <= 8'd0;
    end else begin
      in_en  <= 1'b0;
      iot_in <= 8'd0;
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            cur_src  <= grant_src;
            last_src <= grant_src;
            fn_sel   <= grant_src ? req_fn1 : req_fn0;
            rec_cnt  <= '0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (owner_valid) begin
            shreg    <= cur_src ? req_data1 : req_data0;
            byte_cnt <= 4'd0;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          // A busy core freezes the byte position; nothing is dropped.
          if (!busy) begin
            in_en    <= 1'b1;
            iot_in   <= shreg[7:0];
            shreg    <= {8'h00, shreg[127:8]};
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == 4'hF) begin
              rec_cnt <= rec_cnt + RC_W'(1);
              if (rec_cnt == REC_LAST) begin
                drain_cnt <= '0;
                state     <= S_DRAIN;
              end else begin
                state <= S_LOAD;
              end
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= S_IDLE;
          end else begin
            drain_cnt <= drain_cnt + DC_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Result tagging is state independent so late pulses keep the round owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= 128'd0;
      res_src   <= 1'b0;
    end else begin
      res_valid <= valid;
      if (valid) begin
        res_data <= iot_out;
      end
      res_src <= cur_src;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iotdf_round_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_iotdf_round_arb: directed, table-driven bench for iotdf_round_arb.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_iotdf_round_arb;

  localparam int ROUND_LEN = 8;
  localparam int DRAIN_CYC = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] req_data0, req_data1;
  logic [2:0]   req_fn0 = 3'd0, req_fn1 = 3'd0;
  logic         in_en;
  logic [7:0]   iot_in;
  logic [2:0]   fn_sel;
  logic         busy = 1'b0;
  logic         valid = 1'b0;
  logic [127:0] iot_out = 128'd0;
  logic         res_valid;
  logic [127:0] res_data;
  logic         res_src;

  iotdf_round_arb #(.ROUND_LEN(ROUND_LEN), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_fn0(req_fn0), .req_fn1(req_fn1),
    .in_en(in_en), .iot_in(iot_in), .fn_sel(fn_sel),
    .busy(busy), .valid(valid), .iot_out(iot_out),
    .res_valid(res_valid), .res_data(res_data), .res_src(res_src)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rec(input int s, input int i);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[b*8 +: 8] = 8'((s*144 + i*29 + b*7 + 1) % 256);
    return r;
  endfunction

  // Record sources: each presents its next record until its limit is reached.
  int   idx0 = 0, idx1 = 0;
  int   lim0 = 0, lim1 = 0;
  logic en0 = 1'b0, en1 = 1'b0, hold0 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx0 <= 0;
      idx1 <= 0;
    end else begin
      if (req_valid[0] && req_ready[0]) idx0 <= idx0 + 1;
      if (req_valid[1] && req_ready[1]) idx1 <= idx1 + 1;
    end
  end

  always_comb begin
    req_valid[0] = en0 && !hold0 && (idx0 < lim0);
    req_valid[1] = en1 && (idx1 < lim1);
    req_data0    = rec(0, idx0);
    req_data1    = rec(1, idx1);
  end

  typedef struct packed {
    logic [7:0] b;
    logic [2:0] fn;
  } exp_t;

  typedef struct packed {
    logic         valid;
    logic [127:0] dat;
    logic         exp_rv;
    logic [127:0] exp_rd;
    logic         exp_src;
  } vec_t;

  exp_t exp_q[$];
  int   gap_q[$];
  int   rd_ptr = 0;
  int   zrun = 0;
  bit   started = 1'b0;
  int   vecs = 0;
  int   errs = 0;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and score any byte the core receives in that cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (in_en) begin
      if (rd_ptr >= exp_q.size()) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_byte: got %0h, expected no byte", iot_in);
      end else begin
        chk("byte", iot_in, exp_q[rd_ptr].b);
        chk("fn_sel_during_byte", fn_sel, exp_q[rd_ptr].fn);
        rd_ptr++;
      end
      if (started && zrun > 0) gap_q.push_back(zrun);
      zrun    = 0;
      started = 1'b1;
    end else if (started) begin
      zrun++;
    end
  endtask

  task automatic push_recs(input int s, input int first, input int n, input logic [2:0] fn);
    logic [127:0] r;
    exp_t         e;
    for (int i = first; i < first + n; i++) begin
      r = rec(s, i);
      for (int b = 0; b < 16; b++) begin
        e.b  = r[b*8 +: 8];
        e.fn = fn;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en0 = 1'b0; en1 = 1'b0; hold0 = 1'b0;
    busy = 1'b0; valid = 1'b0; iot_out = 128'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    rd_ptr  = exp_q.size();
    started = 1'b0;
    zrun    = 0;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (rd_ptr < exp_q.size() && n < bound) begin
      tick();
      n++;
    end
    chk("drain_timeout", 128'(rd_ptr), 128'(exp_q.size()));
  endtask

  initial begin
    logic [127:0] a_d, b_d, c_d, r;
    int gm, base;
    logic exp_en;

    a_d = 128'hDEADBEEF_00112233_44556677_8899AABB;
    b_d = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    c_d = 128'hFFFFFFFF_00000000_FFFFFFFF_00000001;
    tbl[0] = '{1'b1, a_d,    1'b1, a_d,    1'b1};
    tbl[1] = '{1'b0, b_d,    1'b0, a_d,    1'b1};
    tbl[2] = '{1'b1, b_d,    1'b1, b_d,    1'b1};
    tbl[3] = '{1'b1, c_d,    1'b1, c_d,    1'b1};
    tbl[4] = '{1'b0, 128'd0, 1'b0, c_d,    1'b1};
    tbl[5] = '{1'b1, 128'd0, 1'b1, 128'd0, 1'b1};

    // Reset state, with activity on every input while reset is held.
    en0 = 1'b1; en1 = 1'b1; lim0 = 1; lim1 = 1; req_fn0 = 3'd3; req_fn1 = 3'd5;
    valid = 1'b1; iot_out = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_en", in_en, 1'b0);
    chk("rst_iot_in", iot_in, 8'd0);
    chk("rst_fn_sel", fn_sel, 3'd0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 128'd0);
    chk("rst_res_src", res_src, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);

    // Single requester 0, fn 1, full round.
    do_reset();
    req_fn0 = 3'd1; lim0 = 8; en0 = 1'b1;
    push_recs(0, 0, 8, 3'd1);
    gm = gap_q.size();
    for (int c = 0; c < 146; c++) begin
      tick();
      if (c == 0) begin
        chk("t1_fn_sel_after_grant", fn_sel, 3'd1);
        chk("t1_req_ready_load", req_ready, 2'b01);
      end
      exp_en = (c >= 2) && (c <= 136) && (((c - 2) % 17) < 16);
      chk("t1_in_en", in_en, exp_en);
    end
    chk("t1_left", 128'(rd_ptr), 128'(exp_q.size()));
    chk("t1_ngaps", 128'(gap_q.size() - gm), 128'd7);
    for (int k = 0; k < gap_q.size() - gm; k++) chk("t1_gap", 128'(gap_q[gm+k]), 128'd1);

    // Both requesting: rounds 0,1,0,1 with fn 2,3,2,3.
    do_reset();
    req_fn0 = 3'd2; req_fn1 = 3'd3; lim0 = 16; lim1 = 16; en0 = 1'b1; en1 = 1'b1;
    push_recs(0, 0, 8, 3'd2);
    push_recs(1, 0, 8, 3'd3);
    push_recs(0, 8, 8, 3'd2);
    push_recs(1, 8, 8, 3'd3);
    gm = gap_q.size();
    wait_drain(2000);
    repeat (8) tick();
    chk("t2_ngaps", 128'(gap_q.size() - gm), 128'd31);
    for (int k = 0; k < gap_q.size() - gm; k++)
      chk("t2_gap", 128'(gap_q[gm+k]), ((k % 8) == 7) ? 128'd7 : 128'd1);

    // Busy for three cycles over byte 5.
    do_reset();
    req_fn0 = 3'd4; lim0 = 1; en0 = 1'b1;
    push_recs(0, 0, 1, 3'd4);
    for (int c = 0; c < 25; c++) begin
      tick();
      exp_en = ((c >= 2) && (c <= 6)) || ((c >= 10) && (c <= 20));
      chk("t3_in_en", in_en, exp_en);
      if (c == 6) busy = 1'b1;
      if (c == 9) busy = 1'b0;
    end
    chk("t3_left", 128'(rd_ptr), 128'(exp_q.size()));

    // Owner 0 stalls between records 3 and 4 while requester 1 waits.
    do_reset();
    req_fn0 = 3'd1; req_fn1 = 3'd7; lim0 = 8; lim1 = 8; en0 = 1'b1; en1 = 1'b1;
    push_recs(0, 0, 8, 3'd1);
    push_recs(1, 0, 8, 3'd7);
    for (int c = 0; c <= 68; c++) tick();
    hold0 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t4_stall_in_en", in_en, 1'b0);
      chk("t4_stall_req_ready", req_ready, 2'b00);
    end
    hold0 = 1'b0;
    wait_drain(2000);

    // Result pulse during the drain after requester 1's round.
    valid = 1'b1; iot_out = 128'h0123456789ABCDEF0123456789ABCDEF;
    tick();
    valid = 1'b0; iot_out = 128'd0;
    chk("t5_res_valid", res_valid, 1'b1);
    chk("t5_res_data", res_data, 128'h0123456789ABCDEF0123456789ABCDEF);
    chk("t5_res_src", res_src, 1'b1);
    chk("t5_in_en", in_en, 1'b0);

    for (int v = 0; v < 6; v++) begin
      valid = tbl[v].valid;
      iot_out = tbl[v].dat;
      tick();
      chk("tbl_res_valid", res_valid, tbl[v].exp_rv);
      chk("tbl_res_data", res_data, tbl[v].exp_rd);
      chk("tbl_res_src", res_src, tbl[v].exp_src);
    end
    valid = 1'b0;
    chk("t4_left", 128'(rd_ptr), 128'(exp_q.size()));

    // Reset asserted while byte 7 of record 2 is on the bus.
    do_reset();
    req_fn0 = 3'd5; req_fn1 = 3'd6; lim0 = 8; lim1 = 8; en0 = 1'b1; en1 = 1'b1;
    base = rd_ptr;
    push_recs(0, 0, 8, 3'd5);
    for (int c = 0; c <= 43; c++) begin
      tick();
      if (c == 42) begin
        valid = 1'b1; iot_out = 128'h5A5A;
      end
    end
    r = rec(0, 2);
    chk("t6_pre_in_en", in_en, 1'b1);
    chk("t6_pre_byte7", iot_in, r[63:56]);
    chk("t6_pre_res_valid", res_valid, 1'b1);
    chk("t6_pre_fn_sel", fn_sel, 3'd5);
    chk("t6_bytes_before_rst", 128'(rd_ptr - base), 128'd40);
    #1;
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    chk("t6_rst_in_en", in_en, 1'b0);
    chk("t6_rst_iot_in", iot_in, 8'd0);
    chk("t6_rst_fn_sel", fn_sel, 3'd0);
    chk("t6_rst_res_valid", res_valid, 1'b0);
    chk("t6_rst_res_data", res_data, 128'd0);
    chk("t6_rst_req_ready", req_ready, 2'b00);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    rd_ptr  = exp_q.size();
    started = 1'b0;
    zrun    = 0;
    push_recs(0, 0, 8, 3'd5);
    push_recs(1, 0, 8, 3'd6);
    tick();
    chk("t6_regrant_fn_sel", fn_sel, 3'd5);
    chk("t6_regrant_req_ready", req_ready, 2'b01);
    wait_drain(2000);
    repeat (10) tick();
    chk("t6_left", 128'(rd_ptr), 128'(exp_q.size()));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
